// File: rtl/pipe_alu.sv
// pipe_alu: two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 captures operands and the raw (wrapping) result; S2 applies saturation
// and prepares the flag candidates. Architectural N/Z/V flags commit only
// when the owning result is handed off downstream.
// Optional feature: define PIPE_ALU_ROR_EN to build the rotate-right opcode;
// without it opcode 1000 is treated as illegal and no rotator exists.
module pipe_alu #(
   parameter int WIDTH  = 16,
   parameter int SAT_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_opcode,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result,
   output logic                     out_illegal,
   output logic                     flag_n,
   output logic                     flag_z,
   output logic                     flag_v
);

   localparam int LANES = WIDTH / 8;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_PADDSB = 4'b0001;
   localparam logic [3:0] OP_SUB    = 4'b0010;
   localparam logic [3:0] OP_AND    = 4'b0011;
   localparam logic [3:0] OP_NOR    = 4'b0100;
   localparam logic [3:0] OP_SLL    = 4'b0101;
   localparam logic [3:0] OP_SRL    = 4'b0110;
   localparam logic [3:0] OP_SRA    = 4'b0111;
`ifdef PIPE_ALU_ROR_EN
   localparam logic [3:0] OP_ROR    = 4'b1000;
`endif

   // Signed overflow of r = a + b: operands agree in sign, result does not.
   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   // Saturation rail chosen by the sign of the overflowing operands.
   function automatic logic signed [WIDTH-1:0] sat_limit(input logic neg);
      return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   // Per-byte-lane saturation of an already wrapped lane-wise sum.
   function automatic logic [WIDTH-1:0] sat_lanes(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] r);
      logic [WIDTH-1:0] q;
      q = r;
      for (int i = 0; i < LANES; i++) begin
         if ((a[i*8+7] == b[i*8+7]) && (r[i*8+7] != a[i*8+7]))
            q[i*8 +: 8] = a[i*8+7] ? 8'h80 : 8'h7F;
      end
      return q;
   endfunction

`ifdef PIPE_ALU_ROR_EN
   // Rotate right; a shift by WIDTH on the left half yields zero for sh = 0.
   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] a,
                                             input logic [$clog2(WIDTH)-1:0] sh);
      return (a >> sh) | (a << (WIDTH - int'(sh)));
   endfunction
`endif

   logic                     adv_p1, adv_p2;
   logic signed [WIDTH-1:0]  raw_d, res_d;
   logic                     illegal_d, v_d, upd_nv_d, upd_z_d;

   logic                     vld_p1;
   logic [3:0]               opcode_p1;
   logic signed [WIDTH-1:0]  a_p1, b_p1, raw_p1;
   logic                     illegal_p1;

   logic                     vld_p2;
   logic signed [WIDTH-1:0]  res_p2;
   logic                     illegal_p2, n_p2, z_p2, v_p2, upd_nv_p2, upd_z_p2;

   // A stage moves when it is empty or the stage after it is moving.
   assign adv_p2      = !vld_p2 || out_ready;
   assign adv_p1      = !vld_p1 || adv_p2;
   assign in_ready    = adv_p1;
   assign out_valid   = vld_p2;
   assign out_result  = res_p2;
   assign out_illegal = illegal_p2;

   // ---- S1: raw result from the incoming operands ----
   // Raw (wrapping) result and opcode legality decode.
   always_comb begin
      raw_d     = '0;
      illegal_d = 1'b0;
      case (in_opcode)
         OP_ADD:    raw_d = in_a + in_b;
         OP_SUB:    raw_d = in_a - in_b;
         OP_PADDSB: begin
            for (int i = 0; i < LANES; i++)
               raw_d[i*8 +: 8] = in_a[i*8 +: 8] + in_b[i*8 +: 8];
         end
         OP_AND:    raw_d = in_a & in_b;
         OP_NOR:    raw_d = ~(in_a | in_b);
         OP_SLL:    raw_d = in_a << in_shamt;
         OP_SRL:    raw_d = in_a >> in_shamt;
         OP_SRA:    raw_d = $signed(in_a) >>> in_shamt;
`ifdef PIPE_ALU_ROR_EN
         OP_ROR:    raw_d = rotr(in_a, in_shamt);
`endif
         default:   illegal_d = 1'b1;
      endcase
   end

   // S1 occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_p1 <= 1'b0;
      else if (adv_p1)
         vld_p1 <= in_valid;
   end

   // S1 payload, loaded only on an accepted operation.
   always_ff @(posedge clk) begin
      if (adv_p1 && in_valid) begin
         opcode_p1  <= in_opcode;
         a_p1       <= in_a;
         b_p1       <= in_b;
         raw_p1     <= raw_d;
         illegal_p1 <= illegal_d;
      end
   end

   // ---- S2: saturation and flag candidates ----
   // Saturated result, overflow and which flags this opcode owns.
   always_comb begin
      res_d    = raw_p1;
      v_d      = 1'b0;
      upd_nv_d = 1'b0;
      upd_z_d  = 1'b0;
      case (opcode_p1)
         OP_ADD, OP_SUB: begin
            v_d = add_ovf(a_p1, (opcode_p1 == OP_SUB) ? ~b_p1 : b_p1, raw_p1);
            if ((SAT_EN != 0) && v_d)
               res_d = sat_limit(a_p1[WIDTH-1]);
            upd_nv_d = 1'b1;
            upd_z_d  = 1'b1;
         end
         OP_PADDSB: res_d = sat_lanes(a_p1, b_p1, raw_p1);
         OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: upd_z_d = 1'b1;
`ifdef PIPE_ALU_ROR_EN
         OP_ROR:    upd_z_d = 1'b1;
`endif
         default:   res_d = '0;
      endcase
   end

   // S2 occupancy and the visible result, held while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2     <= 1'b0;
         res_p2     <= '0;
         illegal_p2 <= 1'b0;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            res_p2     <= res_d;
            illegal_p2 <= illegal_p1;
         end
      end
   end

   // S2 flag candidates, derived from the post-saturation result.
   always_ff @(posedge clk) begin
      if (adv_p2 && vld_p1) begin
         n_p2      <= res_d[WIDTH-1];
         z_p2      <= (res_d == '0);
         v_p2      <= v_d;
         upd_nv_p2 <= upd_nv_d;
         upd_z_p2  <= upd_z_d;
      end
   end

   // ---- Output handshake: architectural flag commit ----
   // Flags change only when the owning result is accepted downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         flag_v <= 1'b0;
      end else if (vld_p2 && out_ready) begin
         if (upd_nv_p2) begin
            flag_n <= n_p2;
            flag_v <= v_p2;
         end
         if (upd_z_p2)
            flag_z <= z_p2;
      end
   end

endmodule

// File: tb/tb_pipe_alu.sv
// Testbench for pipe_alu (WIDTH=16, SAT_EN=1): directed vector table,
// backpressure and mid-flight reset sequences, then randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_pipe_alu;

   localparam int W      = 16;
   localparam int SAT_EN = 1;

   logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]    in_opcode, in_shamt;
   logic [W-1:0]  in_a, in_b, out_result;
   logic          out_illegal, flag_n, flag_z, flag_v;

   pipe_alu #(.WIDTH(W), .SAT_EN(SAT_EN)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_illegal(out_illegal),
      .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a, b;
      logic [3:0]  sh;
      logic [15:0] res;
      logic        ill;
      logic [2:0]  nzv;   // flags {N,Z,V} after the result is accepted
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic        ill, unv, uz, n, z, v;
   } exp_t;

   vec_t tbl[18];
   exp_t q[$];
   logic mn, mz, mv;

   // Reference: plain integer arithmetic straight from the opcode definitions.
   function automatic exp_t ref_op(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] sh);
      exp_t e;
      int sa, sb, s, la, lb, l;
      sa = $signed(a);
      sb = $signed(b);
      e.res = 16'h0; e.ill = 1'b0; e.unv = 1'b0; e.uz = 1'b0; e.v = 1'b0;
      case (op)
         4'd0, 4'd2: begin
            s = (op == 4'd0) ? sa + sb : sa - sb;
            e.v = (s > 32767) || (s < -32768);
            if (SAT_EN != 0 && s > 32767)       e.res = 16'h7FFF;
            else if (SAT_EN != 0 && s < -32768) e.res = 16'h8000;
            else                                e.res = s[15:0];
            e.unv = 1'b1; e.uz = 1'b1;
         end
         4'd1: begin
            for (int i = 0; i < 2; i++) begin
               la = $signed(a[i*8 +: 8]);
               lb = $signed(b[i*8 +: 8]);
               l = la + lb;
               if (l > 127) l = 127;
               if (l < -128) l = -128;
               e.res[i*8 +: 8] = l[7:0];
            end
         end
         4'd3: begin e.res = a & b;     e.uz = 1'b1; end
         4'd4: begin e.res = ~(a | b);  e.uz = 1'b1; end
         4'd5: begin e.res = a << sh;   e.uz = 1'b1; end
         4'd6: begin e.res = a >> sh;   e.uz = 1'b1; end
         4'd7: begin s = sa >>> sh; e.res = s[15:0]; e.uz = 1'b1; end
`ifdef PIPE_ALU_ROR_EN
         4'd8: begin e.res = (a >> sh) | (a << (16 - int'(sh))); e.uz = 1'b1; end
`endif
         default: e.ill = 1'b1;
      endcase
      e.n = e.res[15];
      e.z = (e.res == 16'h0);
      return e;
   endfunction

   // One operation with no backpressure: checks latency, result and flag timing.
   task automatic run_vec(input int i);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_opcode = tbl[i].op; in_a = tbl[i].a;
      in_b = tbl[i].b; in_shamt = tbl[i].sh;
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d early out_valid", i), out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d result", i), out_result, tbl[i].res);
      chk($sformatf("v%0d illegal", i), out_illegal, tbl[i].ill);
      @(negedge clk);
      chk($sformatf("v%0d flags", i), {flag_n, flag_z, flag_v}, tbl[i].nzv);
      chk($sformatf("v%0d drained", i), out_valid, 0);
   endtask

   // Four ADDs against a stalled output, then release and collect in order.
   task automatic bp_test();
      int acc, got;
      logic hs;
      acc = 0; got = 0;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_opcode = 4'd0;
      in_a = 16'd1; in_b = 16'd1; in_shamt = 4'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) begin
            acc++;
            if (acc < 4) begin in_a = 16'(acc + 1); in_b = 16'(acc + 1); end
            else in_valid = 1'b0;
         end
      end
      chk("bp accepted while stalled", acc, 2);
      @(negedge clk);
      chk("bp in_ready stalled", in_ready, 0);
      chk("bp held result", out_result, 16'd2);
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < 20; c++) begin
         hs = in_valid && in_ready;
         if (out_valid && out_ready) begin
            got++;
            chk("bp order", out_result, 16'(2 * got));
         end
         @(posedge clk); #1;
         if (hs) begin
            acc++;
            if (acc < 4) begin in_a = 16'(acc + 1); in_b = 16'(acc + 1); end
            else in_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("bp total accepted", acc, 4);
      chk("bp total delivered", got, 4);
   endtask

   // Two ops in flight, asynchronous reset between clock edges.
   task automatic reset_test();
      int seen;
      run_vec(0);                 // leaves V=1 so the flag clear is visible
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_opcode = 4'd0;
      in_a = 16'd3; in_b = 16'd3;
      @(posedge clk); #1;
      in_a = 16'd4; in_b = 16'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst pre out_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst async out_valid", out_valid, 0);
      chk("rst async result", out_result, 0);
      chk("rst async illegal", out_illegal, 0);
      chk("rst async flags", {flag_n, flag_z, flag_v}, 0);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("rst in_ready after", in_ready, 1);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("rst no stale result", seen, 0);
      chk("rst flags stay clear", {flag_n, flag_z, flag_v}, 0);
   endtask

   function automatic logic [15:0] pick();
      case ($urandom % 6)
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   // Random traffic on both handshakes, scoreboarded against ref_op.
   task automatic random_test();
      exp_t e;
      logic stall, s_ill;
      logic [15:0] s_res;
      mn = 1'b0; mz = 1'b0; mv = 1'b0;
      stall = 1'b0; s_res = 16'h0; s_ill = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         in_valid  = (cyc < 2600) && ($urandom % 4 != 0);
         out_ready = ($urandom % 3 != 0);
         in_opcode = 4'($urandom);
         in_a      = pick();
         in_b      = pick();
         in_shamt  = 4'($urandom);
         @(negedge clk);
         chk("rnd flags", {flag_n, flag_z, flag_v}, {mn, mz, mv});
         if (stall) begin
            chk("rnd hold valid", out_valid, 1);
            chk("rnd hold result", out_result, s_res);
            chk("rnd hold illegal", out_illegal, s_ill);
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("rnd spurious output", 1, 0);
            end else if (out_ready) begin
               e = q.pop_front();
               chk("rnd result", out_result, e.res);
               chk("rnd illegal", out_illegal, e.ill);
               if (e.unv) begin mn = e.n; mv = e.v; end
               if (e.uz) mz = e.z;
            end
         end
         if (in_valid && in_ready)
            q.push_back(ref_op(in_opcode, in_a, in_b, in_shamt));
         stall = out_valid && !out_ready;
         s_res = out_result;
         s_ill = out_illegal;
      end
      chk("rnd all delivered", q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_opcode = 4'd0; in_a = '0; in_b = '0;
      in_shamt = 4'd0; out_ready = 1'b1;

      //          op     a        b        sh     res      ill   NZV
      tbl[0]  = '{4'd0, 16'd10000, 16'd25000, 4'd0, 16'h7FFF, 1'b0, 3'b001};
      tbl[1]  = '{4'd2, 16'd10,  16'd10,   4'd0, 16'h0000, 1'b0, 3'b010};
      tbl[2]  = '{4'd3, 16'hFFFF, 16'hF0F0, 4'd0, 16'hF0F0, 1'b0, 3'b000};
      tbl[3]  = '{4'd1, 16'h7050, 16'h2040, 4'd0, 16'h7F7F, 1'b0, 3'b000};
      tbl[4]  = '{4'd5, 16'h8808, 16'h0000, 4'd1, 16'h1010, 1'b0, 3'b000};
      tbl[5]  = '{4'd7, 16'h8808, 16'h0000, 4'd1, 16'hC404, 1'b0, 3'b000};
`ifdef PIPE_ALU_ROR_EN
      tbl[6]  = '{4'd8, 16'h8808, 16'h0000, 4'd1, 16'h4404, 1'b0, 3'b000};
`else
      tbl[6]  = '{4'd8, 16'h8808, 16'h0000, 4'd1, 16'h0000, 1'b1, 3'b000};
`endif
      tbl[7]  = '{4'd0, 16'h8000, 16'hFFFF, 4'd0, 16'h8000, 1'b0, 3'b101};
      tbl[8]  = '{4'd3, 16'h0F0F, 16'hF0F0, 4'd0, 16'h0000, 1'b0, 3'b111};
      tbl[9]  = '{4'hF, 16'h1234, 16'h5678, 4'd0, 16'h0000, 1'b1, 3'b111};
      tbl[10] = '{4'd2, 16'd5,   16'd7,    4'd0, 16'hFFFE, 1'b0, 3'b100};
      tbl[11] = '{4'd6, 16'h8808, 16'h0000, 4'd3, 16'h1101, 1'b0, 3'b100};
      tbl[12] = '{4'd4, 16'h00FF, 16'h0F00, 4'd0, 16'hF000, 1'b0, 3'b100};
      tbl[13] = '{4'd2, 16'h8000, 16'h0001, 4'd0, 16'h8000, 1'b0, 3'b101};
      tbl[14] = '{4'd2, 16'h7FFF, 16'hFFFF, 4'd0, 16'h7FFF, 1'b0, 3'b001};
      tbl[15] = '{4'd1, 16'h8080, 16'hFFFF, 4'd0, 16'h8080, 1'b0, 3'b001};
      tbl[16] = '{4'd7, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 1'b0, 3'b001};
      tbl[17] = '{4'd5, 16'h8000, 16'h0000, 4'd1, 16'h0000, 1'b0, 3'b011};

      @(posedge clk); #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset result", out_result, 0);
      chk("reset illegal", out_illegal, 0);
      chk("reset flags", {flag_n, flag_z, flag_v}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready after reset", in_ready, 1);

      for (int i = 0; i < 18; i++) run_vec(i);
      bp_test();
      reset_test();
      random_test();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter SAT_EN, default 1, where 1 selects saturating ADD/SUB and 0 selects wrapping ADD/SUB.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: operation present on the in_* ports.
REQ-006 Port in_ready, output, 1 bit: block accepts the operation this cycle.
REQ-007 Port in_opcode, input, 4 bits: ADD 0000, PADDSB 0001, SUB 0010, AND 0011, NOR 0100, SLL 0101, SRL 0110, SRA 0111, ROR 1000.
REQ-008 Port in_a, input, WIDTH bits: operand A.
REQ-009 Port in_b, input, WIDTH bits: operand B.
REQ-010 Port in_shamt, input, clog2(WIDTH) bits: shift amount.
REQ-011 Port out_valid, output, 1 bit: a result is present on out_result.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 Port out_result, output, WIDTH bits: the result.
REQ-014 Port out_illegal, output, 1 bit: the result came from an unsupported opcode.
REQ-015 Ports flag_n, flag_z, flag_v, outputs, 1 bit each: architectural N, Z and V flag registers.

Function
REQ-016 The block SHALL be a two-stage pipeline: S1 registers operands and the raw result; S2 registers the saturated result and the flag candidates.
REQ-017 Latency from input handshake (in_valid & in_ready) to out_valid SHALL be exactly 2 cycles when there is no backpressure; throughput SHALL be 1 op per cycle.
REQ-018 S2 SHALL advance when S2 is empty or out_ready=1; S1 SHALL advance when S1 is empty or S2 advances; in_ready SHALL equal the S1-advance condition, combinationally.
REQ-019 While out_valid=1 and out_ready=0, out_result, out_illegal and out_valid SHALL hold stable.
REQ-020 No operation SHALL be dropped or duplicated under any in_valid/out_ready pattern; results SHALL leave in input order.
REQ-021 ADD/SUB, SAT_EN=1: on signed overflow the result SHALL be 0x7FF..F for positive overflow and 0x800..0 for negative overflow, with V=1.
REQ-022 ADD/SUB, SAT_EN=0: the result SHALL wrap; V SHALL still flag signed overflow.
REQ-023 PADDSB: each 8-bit lane (WIDTH/8 lanes) SHALL be added independently and saturated to 0x7F or 0x80.
REQ-024 SLL/SRL SHALL be logical shifts; SRA SHALL replicate the sign bit; ROR SHALL rotate right by in_shamt.
REQ-025 AND and NOR SHALL be bitwise.
REQ-026 N and Z SHALL be computed from the final (post-saturation) result.
REQ-027 ADD and SUB SHALL update N, Z and V.
REQ-028 AND, NOR and the shifts SHALL update Z only.
REQ-029 PADDSB and illegal opcodes SHALL update no flag.
REQ-030 Flags SHALL update on the output handshake cycle (out_valid & out_ready) of the owning result, never earlier.
REQ-031 Opcodes 1001-1111 (and 1000 when ROR is compiled out) SHALL produce result 0 and out_illegal=1.
REQ-032 Simultaneous input and output handshakes in the same cycle SHALL both complete.

Reset
REQ-033 On rst=1, both stage valid bits, out_valid, out_result, out_illegal, flag_n, flag_z and flag_v SHALL clear to 0 immediately, regardless of clk.
REQ-034 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-035 Operations in flight when reset asserts mid-operation SHALL be discarded and SHALL NOT update flags.

Configuration
REQ-036 Macro PIPE_ALU_ROR_EN defined: opcode 1000 SHALL perform ROR as in REQ-024.
REQ-037 PIPE_ALU_ROR_EN undefined: opcode 1000 SHALL be illegal per REQ-031, and no rotate logic SHALL be synthesised.

Verification
REQ-038 ADD, WIDTH=16, SAT_EN=1, a=10000, b=25000 -> out_result=0x7FFF two cycles later; after handshake V=1, N=0, Z=0.
REQ-039 SUB, a=10, b=10 -> out_result=0x0000; Z=1, N=0, V=0. Then AND 0xFFFF & 0xF0F0 -> 0xF0F0; Z=0, with N and V unchanged from the SUB.
REQ-040 PADDSB, a=0x7050, b=0x2040 -> out_result=0x7F7F; flags unchanged.
REQ-041 Shifts and rotate, a=0x8808, shamt=1: SLL -> 0x1010; SRA -> 0xC404; ROR (macro defined) -> 0x4404; ROR (macro undefined) -> 0x0000 with out_illegal=1.
REQ-042 Backpressure: issue 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 5 cycles -> in_ready=0 after 2 ops accepted; after out_ready=1 the results 2, 4, 6, 8 emerge in order with none lost.
REQ-043 Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 and flags=0 immediately; no stale result appears afterwards.
